jk_cmd_seq: RTL
===============

# jk_cmd_seq

Command sequencer that sits directly upstream of a JK flip-flop. It accepts queued high-level commands (hold, clear, set or toggle, each repeated for N cycles) over a valid/ready handshake, and drives the flip-flop's `j`/`k` inputs cycle by cycle. It also keeps a shadow model of the flip-flop output and flags any divergence between that model and the real `q` fed back from the flip-flop. The block and the flip-flop share `clk` and `rst`.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `CNT_W`, 8: width of the repeat-count field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept.
- `cmd_op`  in  2  opcode {j,k}: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE.
- `cmd_cnt`  in  CNT_W  apply the op for `cmd_cnt`+1 cycles.
- `j`  out  1  registered J drive to the flip-flop.
- `k`  out  1  registered K drive to the flip-flop.
- `q_fb`  in  1  flip-flop output `q`.
- `q_exp`  out  1  shadow model of `q`.
- `busy`  out  1  FIFO non-empty or a command is executing.
- `mismatch`  out  1  sticky flag: `q_fb` differed from `q_exp`.
- `mismatch_clr`  in  1  clears `mismatch`.

## Operation
- Push: the FIFO stores {op,cnt} on any edge where `cmd_valid && cmd_ready`. `cmd_ready` = !full. There is no bypass path: a command pushed into an empty FIFO is popped on the next edge at the earliest.
- FSM states are IDLE and RUN. A `remaining` counter is CNT_W bits wide.
  - IDLE with FIFO non-empty: pop, set `{j,k}` <= op, `remaining` <= cnt, go to RUN.
  - IDLE with FIFO empty: `{j,k}` <= 00.
  - RUN with `remaining` != 0: decrement; `j`/`k` unchanged.
  - RUN with `remaining` == 0 and FIFO non-empty: pop the next command in the same edge, with no bubble cycle; stay in RUN.
  - RUN with `remaining` == 0 and FIFO empty: `{j,k}` <= 00, go to IDLE.
- Shadow model updates on every edge. `q_exp` <= `q_exp` for 00, 0 for 01, 1 for 10, ~`q_exp` for 11, always computed from the current registered `j`/`k`. This matches what the flip-flop samples on the same edge.
- Checker: on every edge after reset, if `q_fb` != `q_exp` then `mismatch` <= 1.
  - If a set and `mismatch_clr` occur on the same edge, the set wins.
  - Otherwise `mismatch_clr` clears the flag.
- `busy` is combinational: (state == RUN) || !empty.
- Reset: FIFO flushed, FSM to IDLE, `remaining` = 0, `j` = `k` = 0, `q_exp` = 0, `mismatch` = 0, `cmd_ready` = 1, `busy` = 0. Reset mid-command abandons the command and all queued commands.
- Full FIFO: push stalls. A pop on an edge raises `cmd_ready` only after that edge; there is no same-cycle push-on-pop when full.
- Pushing while the FIFO is empty and the FSM is in RUN is legal; the entry is consumed when `remaining` reaches 0.

## Timing
- Command accepted at edge E0: popped at E1, and `j`/`k` show the op from E1 for exactly `cnt`+1 cycles.
- The flip-flop first samples the op at E2; `q_fb` and `q_exp` both update at E2.
- Command-to-`q` latency: 2 cycles.
- Back-to-back commands: zero idle cycles between them.
- `mismatch` rises one edge after the first differing cycle.

## Structure
- Package `jk_pkg`: localparams OP_HOLD=2'b00, OP_CLEAR=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11; FSM state encodings ST_IDLE and ST_RUN.
- Sub-module `jk_cmd_fifo`: synchronous FIFO, width 2+CNT_W, depth DEPTH, with `full`/`empty` and synchronous `rst`.
- The top level holds the FSM, `remaining` counter, shadow model and checker.

## Test plan
- Reset with idle inputs -> `j`=`k`=0, `q_exp`=0, `cmd_ready`=1, `busy`=0, `mismatch`=0.
- SET with cnt=0 pushed at E0 -> `{j,k}`=10 only in the E1–E2 cycle; `q_exp`=1 from E2; `busy` low from E2.
- TOGGLE with cnt=3 -> `{j,k}`=11 for 4 cycles; `q_exp` sequence 1,0,1,0; `{j,k}`=00 afterwards.
- SET cnt=0 then CLEAR cnt=0 pushed on consecutive edges -> `{j,k}`=10 then 01 in adjacent cycles with no 00 between; `q_exp` goes 0→1→0.
- DEPTH=4, six HOLD cnt=10 commands offered continuously -> first popped at E1, `cmd_ready` low once 4 entries are stored; it reasserts one cycle after each pop, and all six execute in order.
- `q_fb` forced to 0 during SET cnt=2 -> `mismatch`=1 one edge after `q_exp` goes to 1; stays 1 after `q_fb` releases; `mismatch_clr` with matching `q` clears it.

Source files
------------

// File: rtl/jk_cmd_seq_pkg.sv
// Shared opcodes, FSM encoding and JK next-state helper for the JK command sequencer.
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    case (jk)
      OP_CLEAR:  jk_next = 1'b0;
      OP_SET:    jk_next = 1'b1;
      OP_TOGGLE: jk_next = ~q;
      default:   jk_next = q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_seq_if.sv
// Command push bus: valid/ready handshake carrying {op, cnt}; ready low stalls the producer.
interface jk_cmd_seq_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO, 1-cycle write-to-read latency, no bypass; push ignored when full, pop when empty.
module jk_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Sequences queued JK commands onto registered j/k (2-cycle command-to-q latency, no bubbles
// between commands), shadows q and flags divergence; cmd_ready drops while the FIFO is full.
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  jk_cmd_seq_if.slave  cmd,
  output logic         j,
  output logic         k,
  input  logic         q_fb,
  output logic         q_exp,
  output logic         busy,
  output logic         mismatch,
  input  logic         mismatch_clr
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             j_q, j_d, k_q, k_d;
  logic             q_exp_q, q_exp_d;
  logic             mismatch_q, mismatch_d;

  logic             fifo_full, fifo_empty, do_pop;
  logic [1:0]       pop_op;
  logic [CNT_W-1:0] pop_cnt;

  jk_cmd_fifo #(
    .WIDTH (2 + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd.cmd_valid && cmd.cmd_ready),
    .push_dat ({cmd.cmd_op, cmd.cmd_cnt}),
    .full     (fifo_full),
    .pop      (do_pop),
    .pop_dat  ({pop_op, pop_cnt}),
    .empty    (fifo_empty)
  );

  // Pop when idle, or on the last cycle of a command so the next one follows with no gap.
  assign do_pop = !fifo_empty && ((state_q == ST_IDLE) || (rem_q == '0));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    j_d        = j_q;
    k_d        = k_q;
    if (do_pop) begin
      {j_d, k_d} = pop_op;
      rem_d      = pop_cnt;
      state_d    = ST_RUN;
    end else if (state_q == ST_IDLE) begin
      {j_d, k_d} = OP_HOLD;
    end else if (rem_q != '0) begin
      rem_d = rem_q - CNT_W'(1);
    end else begin
      {j_d, k_d} = OP_HOLD;
      state_d    = ST_IDLE;
    end
    q_exp_d = jk_next(q_exp_q, {j_q, k_q});
    if (q_fb != q_exp_q) begin
      mismatch_d = 1'b1;
    end else if (mismatch_clr) begin
      mismatch_d = 1'b0;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      q_exp_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      j_q        <= j_d;
      k_q        <= k_d;
      q_exp_q    <= q_exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign cmd.cmd_ready = !fifo_full;
  assign j             = j_q;
  assign k             = k_q;
  assign q_exp         = q_exp_q;
  assign mismatch      = mismatch_q;
  assign busy          = (state_q == ST_RUN) || !fifo_empty;

endmodule
